mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous data/instruction SRAM between the fetch stage (read-only) and the memory stage (byte-enabled reads/writes).
- Issues at most one access per cycle and tracks one outstanding read. Returns read data one cycle after issue.
- Raises a pipeline stall request while any requester waits for a grant.
- Sits between the if/mem stages and the SoC SRAM interface.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_burst_cnt.sv | 37 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and constants for the SRAM port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IWAIT = 2'd1,
        ARB_DWAIT = 2'd2
    } arb_state_e;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b0;

    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_burst_cnt.sv
// rtl/mem_port_arbiter_burst_cnt.sv - saturating count of consecutive data grants while fetch waits
module arb_burst_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = BURST_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous SRAM between fetch (read) and memory (read/write) stages
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_ce,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_req,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_D_BURST);
    localparam logic [ADDR_W-1:0]      WORD_MASK   = ADDR_W'(3);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              at_limit;
    logic              pick_d, pick_i;
    logic              d_is_write;
    logic              burst_inc, burst_clr;

    always_comb begin
        d_is_write = ((|d_we) == WRITE_ENABLE);
        // Data wins ties until it has starved fetch for MAX_D_BURST grants.
        pick_d = cpu_rst_n && d_ce && (!if_req || !at_limit);
        pick_i = cpu_rst_n && if_req && !pick_d;

        if_gnt     = pick_i;
        d_gnt      = pick_d;
        sram_en    = pick_d || pick_i;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (pick_d) begin
            sram_we    = d_we;
            sram_addr  = d_addr & ~WORD_MASK;
            sram_wdata = d_wdata;
        end else if (pick_i) begin
            sram_addr  = if_addr & ~WORD_MASK;
        end

        state_d = ARB_IDLE;
        if (pick_i) begin
            state_d = ARB_IWAIT;
        end else if (pick_d && !d_is_write) begin
            state_d = ARB_DWAIT;
        end

        if_rvalid  = cpu_rst_n && (state_q == ARB_IWAIT);
        d_rvalid   = cpu_rst_n && (state_q == ARB_DWAIT);
        if_rdata_d = if_rvalid ? sram_rdata : if_rdata_q;
        d_rdata_d  = d_rvalid ? sram_rdata : d_rdata_q;
        // Response data is forwarded in its own cycle and then held for the stage.
        if_rdata   = if_rdata_d;
        d_rdata    = d_rdata_d;

        stall_req = cpu_rst_n && ((if_req && !pick_i) || (d_ce && !pick_d) ||
                                  (state_q == ARB_DWAIT));

        burst_inc = pick_d && if_req;
        burst_clr = pick_i || !if_req;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state_q    <= ARB_IDLE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    arb_burst_cnt #(
        .W (BURST_CNT_W)
    ) u_burst_cnt (
        .clk      (cpu_clk_50M),
        .rst_n    (cpu_rst_n),
        .inc      (burst_inc),
        .clr      (burst_clr),
        .limit    (BURST_LIMIT),
        .at_limit (at_limit)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_ce;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        stall_req, sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (4)
    ) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_ce        (d_ce),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .stall_req   (stall_req),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h1000;
        d_ce = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0; sram_rdata = 32'hFFFF_FFFF;
        #12;
        chk("rst_if_gnt",    if_gnt, 0);
        chk("rst_sram_en",   sram_en, 0);
        chk("rst_stall",     stall_req, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid",  d_rvalid, 0);
        chk("rst_if_rdata",  if_rdata, 0);
        chk("rst_d_rdata",   d_rdata, 0);
        chk("rst_sram_addr", sram_addr, 0);
        if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // idle
        #2;
        chk("idle_sram_en", sram_en, 0);
        chk("idle_stall",   stall_req, 0);
        chk("idle_addr",    sram_addr, 0);
        tick();

        // fetch-only stream of three words
        if_req = 1'b1; if_addr = 32'hBFC0_0000; sram_rdata = 32'h0;
        #2;
        chk("f1_if_gnt", if_gnt, 1);
        chk("f1_addr",   sram_addr, 32'hBFC0_0000);
        chk("f1_we",     sram_we, 0);
        chk("f1_rvalid", if_rvalid, 0);
        chk("f1_stall",  stall_req, 0);
        tick();
        sram_rdata = 32'h11;
        #2;
        chk("f2_if_gnt", if_gnt, 1);
        chk("f2_rvalid", if_rvalid, 1);
        chk("f2_rdata",  if_rdata, 32'h11);
        tick();
        sram_rdata = 32'h22;
        #2;
        chk("f3_if_gnt", if_gnt, 1);
        chk("f3_rdata",  if_rdata, 32'h22);
        chk("f3_stall",  stall_req, 0);
        tick();
        if_req = 1'b0; sram_rdata = 32'h33;
        #2;
        chk("f4_if_gnt", if_gnt, 0);
        chk("f4_rvalid", if_rvalid, 1);
        chk("f4_rdata",  if_rdata, 32'h33);
        tick();
        sram_rdata = 32'h99;
        #2;
        chk("f5_rvalid", if_rvalid, 0);
        chk("f5_hold",   if_rdata, 32'h33);
        tick();

        // simultaneous fetch and data read
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_ce = 1'b1; d_addr = 32'h8000_0010; d_we = 4'b0000;
        #2;
        chk("s1_d_gnt",  d_gnt, 1);
        chk("s1_if_gnt", if_gnt, 0);
        chk("s1_stall",  stall_req, 1);
        chk("s1_addr",   sram_addr, 32'h8000_0010);
        tick();
        d_ce = 1'b0; sram_rdata = 32'hDEAD_0001;
        #2;
        chk("s2_d_rvalid", d_rvalid, 1);
        chk("s2_d_rdata",  d_rdata, 32'hDEAD_0001);
        chk("s2_if_gnt",   if_gnt, 1);
        chk("s2_stall",    stall_req, 1);
        chk("s2_addr",     sram_addr, 32'h0000_0100);
        tick();
        if_req = 1'b0; sram_rdata = 32'h55;
        #2;
        chk("s3_if_rvalid", if_rvalid, 1);
        chk("s3_if_rdata",  if_rdata, 32'h55);
        chk("s3_d_rvalid",  d_rvalid, 0);
        chk("s3_d_hold",    d_rdata, 32'hDEAD_0001);
        tick();

        // partial store to an unaligned address
        d_ce = 1'b1; d_addr = 32'h8000_0006; d_we = 4'b0011; d_wdata = 32'hAABB_CCDD;
        #2;
        chk("w_d_gnt", d_gnt, 1);
        chk("w_addr",  sram_addr, 32'h8000_0004);
        chk("w_we",    sram_we, 4'b0011);
        chk("w_wdata", sram_wdata, 32'hAABB_CCDD);
        chk("w_stall", stall_req, 0);
        tick();
        d_ce = 1'b0; d_we = 4'b0000; d_wdata = '0;
        #2;
        chk("w2_d_rvalid", d_rvalid, 0);
        chk("w2_stall",    stall_req, 0);
        chk("w2_sram_en",  sram_en, 0);
        tick();

        // contention burst: fetch gets the 5th slot
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_ce = 1'b1; d_addr = 32'h8000_0020; d_we = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            #2;
            chk($sformatf("b%0d_d_gnt", i),  d_gnt,  (i != 5));
            chk($sformatf("b%0d_if_gnt", i), if_gnt, (i == 5));
            tick();
        end
        if_req = 1'b0; d_ce = 1'b0;
        tick();
        tick();

        // reset while a fetch read is outstanding
        if_req = 1'b1; if_addr = 32'h0000_0300; sram_rdata = 32'h77;
        tick();
        if_req = 1'b0;
        #1;
        chk("r0_pre_rvalid", if_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("r1_rvalid",  if_rvalid, 0);
        chk("r1_sram_en", sram_en, 0);
        chk("r1_stall",   stall_req, 0);
        chk("r1_rdata",   if_rdata, 0);
        tick();
        rst_n = 1'b1;
        #2;
        chk("r2_rvalid", if_rvalid, 0);
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0400; sram_rdata = 32'h88;
        #2;
        chk("r3_if_gnt", if_gnt, 1);
        chk("r3_rvalid", if_rvalid, 0);
        tick();
        if_req = 1'b0;
        #2;
        chk("r4_rvalid", if_rvalid, 1);
        chk("r4_rdata",  if_rdata, 32'h88);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
